// File: rtl/heichips25_pudding_pkg.sv
// Shared constants and operation decode for the pudding daisychain/state register pair.
package heichips25_pudding_pkg;

   localparam int DEFAULT_WIDTH = 128;
   localparam int DEFAULT_OUTW  = 8;
   localparam int PAD_W         = 8;

   // ui_in bit positions
   localparam int DATUM    = 0;
   localparam int SHIFT    = 1;
   localparam int TRANSFER = 2;
   localparam int DIR      = 3;
   localparam int STATEEN  = 4;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_SHIFT,
      OP_CAPTURE,
      OP_RESTORE
   } chain_op_e;

   // Transfer outranks shift; dir only matters while transferring.
   function automatic chain_op_e decode_op(input logic shift,
                                           input logic transfer,
                                           input logic dir);
      if (transfer) return dir ? OP_CAPTURE : OP_RESTORE;
      if (shift)    return OP_SHIFT;
      return OP_HOLD;
   endfunction

endpackage

// File: rtl/heichips25_pudding_if.sv
// Control and observation bundle between the pad mapping and the register pair.
interface heichips25_pudding_if
   import heichips25_pudding_pkg::*;
#(
   parameter int OUTW = DEFAULT_OUTW
);

   logic            datum;
   logic            shift;
   logic            transfer;
   logic            dir;
   logic [OUTW-1:0] chain_msb;
   logic [OUTW-1:0] state_msb;

   modport master (
      output datum, shift, transfer, dir,
      input  chain_msb, state_msb
   );

   modport slave (
      input  datum, shift, transfer, dir,
      output chain_msb, state_msb
   );

endinterface

// File: rtl/pudding_chain.sv
// Daisychain shift register plus shadow state register with bidirectional transfer.
module pudding_chain
   import heichips25_pudding_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int OUTW  = DEFAULT_OUTW
) (
   input  logic                 clk,
   input  logic                 rst,
   heichips25_pudding_if.slave  bus
);

   logic [WIDTH-1:0] daisychain;
   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] daisychain_next;
   logic [WIDTH-1:0] state_next;
   chain_op_e        op;

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves a latch.
      daisychain_next = daisychain;
      state_next      = state;
      op              = decode_op(bus.shift, bus.transfer, bus.dir);
      case (op)
         OP_SHIFT:   daisychain_next = {daisychain[WIDTH-2:0], bus.datum};
         OP_CAPTURE: state_next      = daisychain;
         OP_RESTORE: daisychain_next = state;
         default:    ;
      endcase
   end

   // NOTE: non-blocking assignments keep the two registers swapping on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         daisychain <= '0;
         state      <= '0;
      end else begin
         daisychain <= daisychain_next;
         state      <= state_next;
      end
   end

   assign bus.chain_msb = daisychain[WIDTH-1 -: OUTW];
   assign bus.state_msb = state[WIDTH-1 -: OUTW];

endmodule

// File: rtl/heichips25_pudding.sv
// Tile top: maps pads onto the register pair; analog and power pins stay passive.
module heichips25_pudding
   import heichips25_pudding_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int OUTW  = DEFAULT_OUTW
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   inout  wire        i_in,
   inout  wire        i_out,
   input  wire        VPWR,
   input  wire        VGND
);

   heichips25_pudding_if #(.OUTW(OUTW)) chain_bus ();

   assign chain_bus.datum    = ui_in[DATUM];
   assign chain_bus.shift    = ui_in[SHIFT];
   assign chain_bus.transfer = ui_in[TRANSFER];
   assign chain_bus.dir      = ui_in[DIR];

   // rst_n keeps its harness name but is an active-high reset.
   pudding_chain #(
      .WIDTH (WIDTH),
      .OUTW  (OUTW)
   ) u_chain (
      .clk (clk),
      .rst (rst_n),
      .bus (chain_bus.slave)
   );

   assign uo_out  = chain_bus.chain_msb[OUTW-1 -: PAD_W];
   assign uio_out = chain_bus.state_msb[OUTW-1 -: PAD_W];
   assign uio_oe  = 8'hFF;

   logic unused_pins;
   assign unused_pins = ^{ui_in[7:STATEEN], uio_in, ena, i_in, i_out, VPWR, VGND};

endmodule

// File: tb/tb_heichips25_pudding.sv
// Scoreboard bench for heichips25_pudding: directed vectors plus a random regression.
module tb_heichips25_pudding;

   localparam int WIDTH = 128;

   logic       clk = 1'b0;
   logic       rst;
   logic       stateen;
   logic [2:0] ui_hi;
   logic [7:0] uio_in;
   logic       ena;
   wire  [7:0] ui_in;
   wire  [7:0] uo_out;
   wire  [7:0] uio_out;
   wire  [7:0] uio_oe;
   wire        i_in;
   wire        i_out;

   heichips25_pudding_if #(.OUTW(8)) bus ();

   assign ui_in = {ui_hi, stateen, bus.dir, bus.transfer, bus.shift, bus.datum};
   assign bus.chain_msb = uo_out;
   assign bus.state_msb = uio_out;

   heichips25_pudding #(.WIDTH(WIDTH), .OUTW(8)) dut (
      .clk     (clk),
      .rst_n   (rst),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .ena     (ena),
      .i_in    (i_in),
      .i_out   (i_out),
      .VPWR    (1'b1),
      .VGND    (1'b0)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] uo;
      logic [7:0] uio;
   } exp_t;

   exp_t             sb[$];
   int               checks = 0;
   int               errors = 0;
   logic [WIDTH-1:0] m_chain;
   logic [WIDTH-1:0] m_state;
   logic [WIDTH-1:0] pattern;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Reference behaviour written out directly from the priority rules.
   task automatic model_update(input logic r, input logic sh, input logic tr,
                               input logic dr, input logic d);
      if (r) begin
         m_chain = '0;
         m_state = '0;
      end else if (tr && dr) begin
         m_state = m_chain;
      end else if (tr) begin
         m_chain = m_state;
      end else if (sh) begin
         m_chain = {m_chain[WIDTH-2:0], d};
      end
   endtask

   // Inputs change on the falling edge; the expected post-edge outputs are queued.
   task automatic step(input logic r, input logic sh, input logic tr, input logic dr,
                       input logic d, input bit hand, input logic [7:0] huo,
                       input logic [7:0] huio, input string name);
      exp_t e;
      @(negedge clk);
      rst          = r;
      bus.shift    = sh;
      bus.transfer = tr;
      bus.dir      = dr;
      bus.datum    = d;
      stateen      = 1'($urandom);
      ui_hi        = 3'($urandom);
      uio_in       = 8'($urandom);
      ena          = 1'($urandom);
      model_update(r, sh, tr, dr, d);
      e.name = name;
      e.uo   = hand ? huo  : m_chain[WIDTH-1 -: 8];
      e.uio  = hand ? huio : m_state[WIDTH-1 -: 8];
      sb.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_uo_out"}, uo_out, e.uo);
            check({e.name, "_uio_out"}, uio_out, e.uio);
            check({e.name, "_uio_oe"}, uio_oe, 8'hFF);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      bus.shift    = 1'b0;
      bus.transfer = 1'b0;
      bus.dir      = 1'b0;
      bus.datum    = 1'b0;
      stateen      = 1'b0;
      ui_hi        = 3'b0;
      uio_in       = 8'h00;
      ena          = 1'b1;
      m_chain      = '0;
      m_state      = '0;
      pattern      = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

      #3;
      check("reset_async_uo_out", uo_out, 8'h00);
      check("reset_async_uio_out", uio_out, 8'h00);
      check("reset_async_uio_oe", uio_oe, 8'hFF);

      // Reset held for three cycles while the controls toggle.
      step(1, 1, 0, 0, 1, 1, 8'h00, 8'h00, "reset_hold0");
      step(1, 0, 1, 1, 1, 1, 8'h00, 8'h00, "reset_hold1");
      step(1, 1, 1, 0, 0, 1, 8'h00, 8'h00, "reset_hold2");

      // Load the pattern bit 0 first, then capture it into state.
      for (int i = 0; i < WIDTH; i++)
         step(0, 1, 0, 0, pattern[i], 0, 8'h00, 8'h00, "load_shift");
      step(0, 0, 1, 1, 0, 1, 8'h08, 8'h08, "capture");

      // Scramble the chain, then restore it from state.
      for (int i = 0; i < 10; i++)
         step(0, 1, 0, 0, 1'($urandom), 0, 8'h00, 8'h00, "scramble");
      step(0, 0, 1, 0, 0, 1, 8'h08, 8'h08, "restore");

      // Eight ones pull pattern bits 15..8 to the top byte.
      for (int i = 0; i < 8; i++)
         step(0, 1, 0, 0, 1, 0, 8'h00, 8'h00, "ones_shift");
      step(0, 0, 0, 0, 1, 1, 8'h4C, 8'h08, "ones_idle");
      step(0, 1, 1, 1, 1, 1, 8'h4C, 8'h4C, "priority_capture");
      step(0, 1, 0, 0, 0, 1, 8'h98, 8'h4C, "post_priority_shift");
      step(0, 1, 1, 0, 1, 1, 8'h4C, 8'h4C, "priority_restore");

      // Fifty shifts, then reset must clear both outputs without a clock edge.
      for (int i = 0; i < 50; i++)
         step(0, 1, 0, 0, 1'($urandom), 0, 8'h00, 8'h00, "stream_shift");
      @(negedge clk);
      #2;
      rst = 1'b1;
      model_update(1, 0, 0, 0, 0);
      #1;
      check("midstream_reset_uo_out", uo_out, 8'h00);
      check("midstream_reset_uio_out", uio_out, 8'h00);
      step(1, 1, 1, 1, 1, 1, 8'h00, 8'h00, "reset_during_ops");
      step(0, 1, 0, 0, 1, 0, 8'h00, 8'h00, "resume_shift");

      // Random regression against the reference model.
      for (int i = 0; i < 500; i++)
         step(0, 1'($urandom), 1'($urandom_range(3) == 0), 1'($urandom),
              1'($urandom), 0, 8'h00, 8'h00, "random");

      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", 8'(sb.size()), 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/heichips25_pudding.md
HEICHIPS25_PUDDING -- requirements
Module: heichips25_pudding

Interface
- REQ-001 SHALL have one clock; reset is asynchronous and active-high.
- REQ-002 SHALL provide parameter WIDTH, default 128, giving the length of the daisychain and state registers.
- REQ-003 SHALL provide parameter OUTW, default 8, giving the number of MSBs exposed on the outputs.
- REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock for all registers.
- REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous reset, asserted at logic 1.
  - The name is kept for tile-harness pin compatibility.
- REQ-006 SHALL have port ui_in, input, 8 bits: control inputs.
  - [0] datum, [1] shift, [2] transfer, [3] dir, [4] stateen.
  - [7:5] are unused.
- REQ-007 SHALL have port uo_out, output, 8 bits: daisychain[WIDTH-1:WIDTH-8].
- REQ-008 SHALL have port uio_in, input, 8 bits: unused.
- REQ-009 SHALL have port uio_out, output, 8 bits: state[WIDTH-1:WIDTH-8].
- REQ-010 SHALL have port uio_oe, output, 8 bits: bidirectional-pad output enables.
- REQ-011 SHALL have port ena, input, 1 bit: tile enable; it is ignored and does not gate the logic.
- REQ-012 SHALL have ports i_in and i_out, inout, 1 bit each: analog pins.
  - The digital logic never drives them; they are left as high-Z feed-through.
- REQ-013 SHALL have ports VPWR and VGND, input, 1 bit each: power and ground pins, with no logical function.

Function
- REQ-014 SHALL hold two WIDTH-bit registers, daisychain and state, both updated only on the rising edge of clk while reset is deasserted.
- REQ-015 SHALL apply this priority each cycle:
  - When transfer=1 and dir=1: state <= daisychain, and daisychain holds.
  - When transfer=1 and dir=0: daisychain <= state, and state holds.
- REQ-016 SHALL shift when transfer=0 and shift=1: daisychain <= {daisychain[WIDTH-2:0], datum}.
  - The LSB is filled with datum and the MSB is discarded.
  - state holds.
- REQ-017 SHALL hold both registers when transfer=0 and shift=0.
- REQ-018 SHALL ignore shift and datum whenever transfer=1 (transfer has priority).
- REQ-019 SHALL leave both registers unaffected by stateen, ui_in[7:5], uio_in and ena.
- REQ-020 SHALL drive uo_out and uio_out combinationally from the register MSBs, so each update is visible in the cycle after the sampling edge with no extra latency.
- REQ-021 SHALL drive uio_oe constantly to 8'hFF, including during reset.
- REQ-022 SHALL place a bit shifted in as the n-th shift (n = 1..WIDTH) at daisychain[WIDTH-n] after WIDTH consecutive shifts.
  - A WIDTH-bit payload sent bit 0 first therefore ends with payload[0] at the MSB.
  - Bits older than WIDTH shifts are lost.

Reset
- REQ-023 SHALL asynchronously clear daisychain and state to all-zero while rst_n=1, forcing uo_out=8'h00 and uio_out=8'h00 immediately.
- REQ-024 SHALL abort any shift or transfer in progress when reset is asserted mid-operation, with no partial update retained.
- REQ-025 SHALL resume normal operation on the first rising clk edge after rst_n returns to 0.

Structure
- REQ-026 SHALL define the following in a shared package heichips25_pudding_pkg:
  - the default WIDTH/OUTW constants;
  - the ui_in bit-index localparams (DATUM=0, SHIFT=1, TRANSFER=2, DIR=3, STATEEN=4).
- REQ-027 SHALL implement the register pair and its shift/transfer logic in one sub-module pudding_chain, parameterised by WIDTH.
  - The top level only maps pads, drives uio_oe and leaves the analog/power pins passive.

Verification
- REQ-028 SHALL verify reset: hold rst_n=1 for 3 cycles -> uo_out=8'h00, uio_out=8'h00, uio_oe=8'hFF.
- REQ-029 SHALL verify load and capture:
  - Stimulus: shift in pattern 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210 bit 0 first, then pulse transfer with dir=1.
  - Required response: uio_out equals the bit-reversed pattern MSB byte, 8'h08, and uo_out=8'h08.
- REQ-030 SHALL verify restore: after capture, shift 10 random bits, then pulse transfer with dir=0 -> uo_out returns to 8'h08, and uio_out is unchanged.
- REQ-031 SHALL verify priority: assert shift=1, transfer=1, dir=1 and datum=1 in the same cycle -> state <= daisychain, with no shift occurring.
- REQ-032 SHALL verify reset mid-stream: assert rst_n=1 after 50 shifts -> both outputs are 8'h00 immediately, without waiting for a clock edge.
- REQ-033 SHALL verify a random regression:
  - Stimulus: 500 random shift/transfer/idle cycles.
  - Check every cycle: uo_out and uio_out match a reference model of REQ-015..REQ-018, and uio_oe=8'hFF.
